sync_hazard_monitor: RTL

Downstream checker for the generated synchronous model of an asynchronous circuit. It consumes the circuit's per-signal captured values (DFF `Q`) and pre-capture values (`_precap`), along with the per-cycle `fire` index. Each cycle it tracks which signals are excited and counts effective and null firings. It flags semi-modularity hazards (an excited signal disabled without firing) and deadlock (no excited signal for a bounded run of cycles). Its sticky flags are the properties the formal tool asserts against.

---
 rtl/sync_hazard_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sync_hazard_monitor.sv
// Runtime checker for a synchronous model of an asynchronous circuit: tracks excitation,
// flags semi-modularity hazards and deadlock, and counts effective and null firings.
module sync_hazard_monitor #(
  parameter int N           = 8,
  parameter int FIRE_W      = 4,
  parameter int QUIET_LIMIT = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FIRE_W-1:0]    fire,
  input  logic [N-1:0]         cur,
  input  logic [N-1:0]         nxt,
  output logic [N-1:0]         excited,
  output logic                 hazard,
  output logic [$clog2(N)-1:0] hazard_idx,
  output logic                 deadlock,
  output logic [CNT_W-1:0]     fire_count,
  output logic [CNT_W-1:0]     null_count,
  output logic [1:0]           state
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    PRIME   = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        exc_now, dis;
  logic [N-1:0]        exc_prev_p1;
  logic [FIRE_W-1:0]   fire_prev_p1;
  logic [7:0]          quiet_q;
  logic                eff, hazard_set, quiet_now, quiet_hit, counting;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Stage p0: combinational excitation, effective-firing and disabling terms
  always_comb begin
    exc_now = cur ^ nxt;
    eff     = 1'b0;
    dis     = '0;
    for (int i = 0; i < N; i++) begin
      if ((fire == FIRE_W'(i)) && exc_now[i]) eff = 1'b1;
      // A signal that fired last cycle has legitimately left the excited set.
      dis[i] = exc_prev_p1[i] && !exc_now[i] && (fire_prev_p1 != FIRE_W'(i));
    end
  end

  assign counting  = (state_q == MONITOR) || (state_q == FAULT);
  assign quiet_now = (exc_now == '0);
  assign quiet_hit = quiet_now && (quiet_q >= 8'(QUIET_LIMIT - 1));

  always_comb begin
    state_d    = state_q;
    hazard_set = 1'b0;
    case (state_q)
      PRIME:   state_d = MONITOR;
      MONITOR: begin
        if (|dis) begin
          hazard_set = 1'b1;
          state_d    = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PRIME;
    else       state_q <= state_d;
  end

  // Stage p1: registered history, sticky flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_prev_p1  <= '0;
      fire_prev_p1 <= '1;
      excited      <= '0;
      hazard       <= 1'b0;
      hazard_idx   <= '0;
      deadlock     <= 1'b0;
      fire_count   <= '0;
      null_count   <= '0;
      quiet_q      <= '0;
    end else begin
      exc_prev_p1  <= exc_now;
      fire_prev_p1 <= fire;
      excited      <= exc_now;
      if (hazard_set) begin
        hazard     <= 1'b1;
        hazard_idx <= lowest_idx(dis);
      end
      if (counting) begin
        if (eff) fire_count <= sat_inc(fire_count);
        else     null_count <= sat_inc(null_count);
        if (!quiet_now) begin
          quiet_q <= '0;
        end else if (quiet_hit) begin
          quiet_q  <= 8'(QUIET_LIMIT);
          deadlock <= 1'b1;
        end else begin
          quiet_q <= quiet_q + 8'd1;
        end
      end
    end
  end

  assign state = state_q;

endmodule
